// File: rtl/circle.sv
// Midpoint circle rasteriser: emits one octant point per clock to a 160x120 VGA
// adapter, clipping off-screen points while keeping the cycle count fixed.
module circle (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic       start,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic signed [11:0] ox_r, oy_r, crit_r;
    logic signed [11:0] ox_nxt_s, oy_nxt_s, crit_nxt_s;
    logic signed [11:0] ox_step_s, oy_step_s, crit_step_s;
    logic [2:0]         oct_r, oct_nxt_s;
    logic [7:0]         cx_r, cx_nxt_s;
    logic [6:0]         cy_r, cy_nxt_s;
    logic [2:0]         col_r, col_nxt_s;
    logic [23:0]        pt_s;
    logic signed [11:0] pt_x_s, pt_y_s;
    logic               emit_s, in_range_s, plot_nxt_s, done_nxt_s;

    // Point for octant oct, packed as {x, y}; all terms are signed 12-bit so
    // negative and beyond-screen coordinates survive until clipping.
    function automatic logic [23:0] octant_point(
        input logic [2:0]         oct,
        input logic signed [11:0] cx,
        input logic signed [11:0] cy,
        input logic signed [11:0] ox,
        input logic signed [11:0] oy
    );
        logic signed [11:0] px, py;
        case (oct)
            3'd0:    begin px = cx + ox; py = cy + oy; end
            3'd1:    begin px = cx + oy; py = cy + ox; end
            3'd2:    begin px = cx - ox; py = cy + oy; end
            3'd3:    begin px = cx - oy; py = cy + ox; end
            3'd4:    begin px = cx - ox; py = cy - oy; end
            3'd5:    begin px = cx - oy; py = cy - ox; end
            3'd6:    begin px = cx + ox; py = cy - oy; end
            3'd7:    begin px = cx + oy; py = cy - ox; end
            default: begin px = cx;      py = cy;      end
        endcase
        return {px, py};
    endfunction

    // Midpoint step applied after the eighth octant of each iteration.
    always_comb begin
        oy_step_s = oy_r + 12'sd1;
        if (crit_r <= 12'sd0) begin
            ox_step_s   = ox_r;
            crit_step_s = crit_r + 12'sd2 * oy_step_s + 12'sd1;
        end else begin
            ox_step_s   = ox_r - 12'sd1;
            crit_step_s = crit_r + 12'sd2 * (oy_step_s - (ox_r - 12'sd1)) + 12'sd1;
        end
    end

    // Next-state and datapath selection; each emitting transition produces the
    // point that becomes visible on the outputs in the following cycle.
    always_comb begin
        state_nxt_s = state_r;
        ox_nxt_s    = ox_r;
        oy_nxt_s    = oy_r;
        crit_nxt_s  = crit_r;
        oct_nxt_s   = oct_r;
        cx_nxt_s    = cx_r;
        cy_nxt_s    = cy_r;
        col_nxt_s   = col_r;
        pt_s        = 24'd0;
        emit_s      = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = DRAW;
                    cx_nxt_s    = centre_x;
                    cy_nxt_s    = centre_y;
                    col_nxt_s   = colour;
                    ox_nxt_s    = $signed({4'b0000, radius});
                    oy_nxt_s    = 12'sd0;
                    crit_nxt_s  = 12'sd1 - $signed({4'b0000, radius});
                    oct_nxt_s   = 3'd0;
                    emit_s      = 1'b1;
                    pt_s        = octant_point(3'd0, $signed({4'b0000, centre_x}),
                                               $signed({5'b00000, centre_y}),
                                               $signed({4'b0000, radius}), 12'sd0);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAW: begin
                if (oct_r != 3'd7) begin
                    oct_nxt_s = oct_r + 3'd1;
                    emit_s    = 1'b1;
                    pt_s      = octant_point(oct_r + 3'd1, $signed({4'b0000, cx_r}),
                                             $signed({5'b00000, cy_r}), ox_r, oy_r);
                end else if (oy_step_s <= ox_step_s) begin
                    ox_nxt_s   = ox_step_s;
                    oy_nxt_s   = oy_step_s;
                    crit_nxt_s = crit_step_s;
                    oct_nxt_s  = 3'd0;
                    emit_s     = 1'b1;
                    pt_s       = octant_point(3'd0, $signed({4'b0000, cx_r}),
                                              $signed({5'b00000, cy_r}), ox_step_s, oy_step_s);
                end else begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt_s = IDLE;
                end else begin
                    done_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Clip to the visible 160x120 area; hidden points output zero coordinates.
    always_comb begin
        pt_x_s     = $signed(pt_s[23:12]);
        pt_y_s     = $signed(pt_s[11:0]);
        in_range_s = (pt_x_s >= 12'sd0) && (pt_x_s <= 12'sd159) &&
                     (pt_y_s >= 12'sd0) && (pt_y_s <= 12'sd119);
        plot_nxt_s = emit_s && in_range_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Iteration counters and latched draw parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_r   <= 12'sd0;
            oy_r   <= 12'sd0;
            crit_r <= 12'sd0;
            oct_r  <= 3'd0;
            cx_r   <= 8'd0;
            cy_r   <= 7'd0;
            col_r  <= 3'd0;
        end else begin
            ox_r   <= ox_nxt_s;
            oy_r   <= oy_nxt_s;
            crit_r <= crit_nxt_s;
            oct_r  <= oct_nxt_s;
            cx_r   <= cx_nxt_s;
            cy_r   <= cy_nxt_s;
            col_r  <= col_nxt_s;
        end
    end

    // Registered VGA outputs and completion flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else begin
            vga_x      <= plot_nxt_s ? pt_x_s[7:0] : 8'd0;
            vga_y      <= plot_nxt_s ? pt_y_s[6:0] : 7'd0;
            vga_colour <= col_nxt_s;
            vga_plot   <= plot_nxt_s;
            done       <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_circle.sv
// Randomised self-checking bench for circle; expected pixels come from a
// queue-based midpoint model evaluated in plain integer arithmetic.
module tb_circle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic       start;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_checks = 0;
    int n_errors = 0;
    int exp_x[$];
    int exp_y[$];

    circle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .colour     (colour),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .start      (start),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Full sequence of octant points (clipped or not) for one draw.
    task automatic build_expected(input int cx, input int cy, input int r);
        int ox, oy, crit;
        exp_x.delete();
        exp_y.delete();
        ox = r; oy = 0; crit = 1 - r;
        do begin
            for (int k = 0; k < 8; k++) begin
                int a, b, sx, sy;
                a  = (k % 2 == 0) ? ox : oy;
                b  = (k % 2 == 0) ? oy : ox;
                sx = (k < 2 || k >= 6) ? 1 : -1;
                sy = (k < 4) ? 1 : -1;
                exp_x.push_back(cx + sx * a);
                exp_y.push_back(cy + sy * b);
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    task automatic run_draw(input int cx, input int cy, input int r, input int col,
                            input bit hold, input bit check_dist);
        build_expected(cx, cy, r);
        @(negedge clk);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour = 3'(col); start = 1'b1;
        for (int i = 0; i < exp_x.size(); i++) begin
            bit vis;
            @(negedge clk);
            vis = (exp_x[i] >= 0) && (exp_x[i] <= 159) && (exp_y[i] >= 0) && (exp_y[i] <= 119);
            chk("plot", vga_plot, vis);
            chk("done_low", done, 0);
            if (vis) begin
                chk("x", vga_x, exp_x[i]);
                chk("y", vga_y, exp_y[i]);
                chk("colour", vga_colour, col);
            end
            if (check_dist && vga_plot) begin
                int dx, dy, err;
                dx = int'(vga_x) - cx; dy = int'(vga_y) - cy;
                err = dx * dx + dy * dy - r * r;
                chk("dist", (err <= r && err >= -r), 1);
            end
            if (i == 0) begin
                centre_x = 8'($urandom_range(0, 159)); centre_y = 7'($urandom_range(0, 119));
                radius = 8'($urandom); colour = 3'($urandom);
                if (!hold) start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_high", done, 1);
        chk("done_plot", vga_plot, 0);
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk("hold_done", done, 1);
                chk("hold_plot", vga_plot, 0);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_plot", vga_plot, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; colour = 3'd0; centre_x = 8'd0; centre_y = 7'd0; radius = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        rst_n = 1'b1;

        run_draw(80, 60, 0, 2, 1'b0, 1'b0);
        run_draw(80, 60, 1, 5, 1'b0, 1'b0);
        run_draw(0, 0, 10, 7, 1'b0, 1'b0);
        run_draw(159, 119, 30, 1, 1'b0, 1'b0);
        run_draw(80, 60, 40, 6, 1'b1, 1'b1);
        run_draw(80, 60, 40, 6, 1'b1, 1'b1);
        run_draw(80, 60, 255, 4, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_draw($urandom_range(0, 159), $urandom_range(0, 119),
                     $urandom_range(0, 60), $urandom_range(0, 7), 1'($urandom), 1'b0);
        end

        // Abort a radius-20 draw during its third iteration.
        @(negedge clk);
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20; colour = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_plot", vga_plot, 0);
        chk("abort_done", done, 0);
        chk("abort_x", vga_x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_abort_plot", vga_plot, 0);
            chk("post_abort_done", done, 0);
        end
        run_draw(80, 60, 20, 3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
